// File: rtl/lowx_mem_resp_if.sv
// Request/response bundle between a cache miss path (master) and the lowX memory
// responder (slave).
interface lowx_mem_resp_if #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned BLK_SIZE = 128
);
   logic                req_valid;
   logic                req_ready;
   logic [XLEN-1:0]     req_addr;
   logic                req_rw;
   logic [1:0]          req_rw_type;
   logic                req_uncached;
   logic [BLK_SIZE-1:0] req_data;
   logic                res_valid;
   logic                res_ready;
   logic [BLK_SIZE-1:0] res_data;

   modport master (
      output req_valid, req_addr, req_rw, req_rw_type, req_uncached, req_data, res_ready,
      input  req_ready, res_valid, res_data
   );

   modport slave (
      input  req_valid, req_addr, req_rw, req_rw_type, req_uncached, req_data, res_ready,
      output req_ready, res_valid, res_data
   );
endinterface

// File: rtl/lowx_mem_resp.sv
// Fixed-latency block memory responder: serves 128-bit block reads, full-block
// writebacks and uncached byte/half/word writes, one request at a time.
module lowx_mem_resp #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned BLK_SIZE = 128,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned LATENCY  = 4
) (
   input logic             clk_i,
   input logic             rst_ni,
   lowx_mem_resp_if.slave  bus
);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned NB    = BLK_SIZE / 8;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [3:0]          off_q, off_d;
   logic                rw_q, rw_d;
   logic [1:0]          type_q, type_d;
   logic                unc_q, unc_d;
   logic [BLK_SIZE-1:0] wdata_q, wdata_d;
   logic                req_ready_q, req_ready_d;
   logic                res_valid_q, res_valid_d;
   logic [BLK_SIZE-1:0] res_data_q, res_data_d;

   logic [BLK_SIZE-1:0] mem [DEPTH];
   logic [BLK_SIZE-1:0] cur_blk, new_blk, rep;
   logic [NB-1:0]       be;
   logic                do_access;
   logic                mem_we;

   logic unused_addr;
   assign unused_addr = ^bus.req_addr[XLEN-1:4+IDX_W];

   // Block after applying the captured request; equals the stored block for reads.
   always_comb begin
      cur_blk = mem[idx_q];
      be      = '0;
      rep     = '0;
      case (type_q)
         2'b01: begin
            be  = NB'(1) << off_q;
            rep = {NB{wdata_q[7:0]}};
         end
         2'b10: begin
            be  = NB'(3) << {off_q[3:1], 1'b0};
            rep = {(NB/2){wdata_q[15:0]}};
         end
         2'b11: begin
            be  = NB'(15) << {off_q[3:2], 2'b00};
            rep = {(NB/4){wdata_q[31:0]}};
         end
         default: ;
      endcase
      new_blk = cur_blk;
      if (rw_q) begin
         if (!unc_q) begin
            new_blk = wdata_q;
         end else begin
            for (int i = 0; i < int'(NB); i++) begin
               if (be[i]) new_blk[8*i +: 8] = rep[8*i +: 8];
            end
         end
      end
   end

   // LATENCY=1 also passes through one WAIT cycle so the response lands exactly
   // LATENCY edges after accept.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      off_d       = off_q;
      rw_d        = rw_q;
      type_d      = type_q;
      unc_d       = unc_q;
      wdata_d     = wdata_q;
      req_ready_d = req_ready_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      do_access   = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               idx_d       = bus.req_addr[4+IDX_W-1:4];
               off_d       = bus.req_addr[3:0];
               rw_d        = bus.req_rw;
               type_d      = bus.req_rw_type;
               unc_d       = bus.req_uncached;
               wdata_d     = bus.req_data;
               cnt_d       = 8'(LATENCY - 1);
               req_ready_d = 1'b0;
               state_d     = StWait;
            end
         end
         StWait: begin
            if (cnt_q == 8'd0) begin
               do_access   = 1'b1;
               res_valid_d = 1'b1;
               res_data_d  = new_blk;
               state_d     = StResp;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StResp: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         idx_q       <= '0;
         off_q       <= '0;
         rw_q        <= 1'b0;
         type_q      <= '0;
         unc_q       <= 1'b0;
         wdata_q     <= '0;
         req_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         off_q       <= off_d;
         rw_q        <= rw_d;
         type_q      <= type_d;
         unc_q       <= unc_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   // Storage has no reset; a write only commits on the edge entering RESP.
   assign mem_we = do_access && rw_q && rst_ni;

   always_ff @(posedge clk_i) begin
      if (mem_we) mem[idx_q] <= new_blk;
   end

   assign bus.req_ready = req_ready_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
endmodule
